key_event_capture_8: RTL and testbench
======================================

# key_event_capture_8

Upstream front-end for the 8-to-3 encoder. It synchronizes and debounces eight raw active-high request lines and turns each debounced rising edge into a pending event. Pending events are issued one at a time as a registered one-hot word with a valid/ready handshake. The one-hot word drives the encoder's I0..I7 inputs directly, and the handshake tells the consumer when that word is meaningful.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must differ from its debounced level before that level flips. Legal range is 1..255; the counter is 8 bits wide.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronous to clk externally.
- I0..I7  in  1 each  raw asynchronous request lines, active high, I7 highest priority.
- O0..O7  out  1 each  registered one-hot event word to the encoder; all zero when valid=0.
- valid  out  1  O0..O7 holds an undelivered event.
- ready  in  1  consumer accepts the event on a clock edge where valid=1 and ready=1.
- overflow  out  1  sticky flag: an event was lost because its channel was already pending.

## Operation
- Synchronizer: two flip-flops per channel (sync1, sync2), reset to 0.
- Debounce, per channel, using an 8-bit counter cnt and a debounced level stable, both reset to 0:
  - If sync2 == stable, cnt is set to 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1, stable is inverted and cnt is set to 0.
  - Otherwise, cnt increments.
  - Any return to equality before the threshold discards the partial count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Edge detect: the same edge on which stable goes 0->1 sets pending[i].
  - A 1->0 transition of stable generates no event.
- Overflow: if pending[i] is already 1 and is not being granted on that edge when a new rise arrives, overflow is set to 1.
  - overflow stays set until reset, and the extra event is dropped.
- Output stage load condition: the stage loads when it is free, i.e. (valid=0) or (valid=1 and ready=1).
  - On load, it selects the highest-index set bit of pending.
  - O is written with that bit one-hot, valid is set to 1, and the selected pending bit is cleared on the same edge.
  - If pending is all zero, O is set to 0 and valid to 0.
- Set/clear collision: when a new rise on channel i arrives on the same edge that pending[i] is granted, pending[i] stays 1. The new event is kept and overflow is not set.
- Hold rule: while valid=1 and ready=0, O0..O7 and valid are held stable.
  - Pending bits keep accumulating during the hold.
- Back-to-back delivery: on a transfer edge with pending non-zero, the next event loads on that same edge, so valid stays high.
- Reset values: all outputs are 0 (O0..O7, valid, overflow), as is all internal state (sync1, sync2, stable, cnt, pending).
  - Reset mid-operation discards everything in flight: pending events and the held output word.
  - An input that is held high through reset release produces exactly one event after reset.

## Timing
- The output stage is a single register, so O0..O7 and valid change only on clk edges.
- Latency: an input that is high from before edge k, with an idle output stage:
  - sync2 is 1 after edge k+1.
  - stable and pending are 1 after edge k+1+N, where N = DEBOUNCE_CYCLES.
  - valid=1 and O is correct after edge k+2+N (k+6 for N=4).
- Throughput is one event per cycle when ready is held high.
- ready has no combinational path to any output.
- The minimum accepted pulse width at sync2 is N cycles. A pulse of N-1 cycles produces no event.

## Test plan
- Reset: hold rst_n=0 while toggling I0..I7 randomly for 20 cycles -> O0..O7, valid and overflow stay 0 throughout; after release with all inputs low, no event appears.
- Single press, N=4, ready=1: I3 high from before edge k for 10 cycles -> valid=1 with O=00001000 (O3 set) after edge k+6 for exactly one cycle; the release generates no further valid.
- Glitch rejection, N=4: I5 high for 3 cycles, then low -> valid and overflow never assert.
- Priority and hold, ready=0: I1 and I6 rise together -> O6 valid and held stable for 5 cycles. One ready pulse -> the next cycle shows O1 valid. A second ready pulse -> valid drops to 0.
- Overflow, ready=0:
  - Press I7 to occupy the output stage.
  - Then press, release and re-press I2, each phase lasting more than N+2 cycles.
  - Expect overflow=1.
  - Draining with ready=1 then delivers exactly O7 followed by a single O2.
- Reset mid-operation:
  - Setup: I4 is held high, O4 is valid and pending has other bits set.
  - Pulse rst_n low for 2 cycles -> all outputs are 0 immediately, without waiting for a clock edge.
  - After release with ready=1 -> exactly one O4 event after N+2 edges, and nothing else.

Source files
------------

// File: rtl/key_event_capture_8_if.sv
// key_event_capture_8_if: raw request lines in, one-hot event word with valid/ready handshake out
interface key_event_capture_8_if;
  logic [7:0] req;
  logic [7:0] o;
  logic valid;
  logic ready;
  logic overflow;
  modport master (input req, ready, output o, valid, overflow);
  modport slave (output req, ready, input o, valid, overflow);
endinterface

// File: rtl/key_event_capture_8.sv
// key_event_capture_8: synchronize and debounce eight request lines, queue each rising edge as a pending event,
// and issue pending events one at a time as a registered one-hot word, highest channel first
module key_event_capture_8 #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  key_event_capture_8_if.master bus
);
  logic [7:0] sync1_q, sync2_q, stable_q, stable_d, pending_q, pending_d, o_q, o_d;
  logic [7:0] rise, sel, grant;
  logic [7:0][7:0] cnt_q, cnt_d;
  logic valid_q, valid_d, overflow_q, overflow_d, free;
  always_comb begin
    stable_d = stable_q;
    cnt_d = cnt_q;
    for (int j = 0; j < 8; j++) begin
      if (sync2_q[j] == stable_q[j]) cnt_d[j] = '0;
      else if (cnt_q[j] == 8'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[j] = ~stable_q[j];
        cnt_d[j] = '0;
      end else cnt_d[j] = cnt_q[j] + 8'd1;
    end
  end
  always_comb begin
    sel = '0;
    for (int j = 0; j < 8; j++) if (pending_q[j]) sel = 8'd1 << j;
    rise = stable_d & ~stable_q;
    free = ~valid_q | bus.ready;
    grant = free ? sel : '0;
    // a rise on the channel being granted this edge re-arms it instead of overflowing
    pending_d = (pending_q & ~grant) | rise;
    overflow_d = overflow_q | (|(rise & pending_q & ~grant));
    o_d = free ? sel : o_q;
    valid_d = free ? |pending_q : valid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stable_q <= '0;
      cnt_q <= '0;
      pending_q <= '0;
      o_q <= '0;
      valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q <= bus.req;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      pending_q <= pending_d;
      o_q <= o_d;
      valid_q <= valid_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.o = o_q;
  assign bus.valid = valid_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_key_event_capture_8.sv
// tb_key_event_capture_8: scoreboard bench; expected one-hot words are queued as stimulus is driven
// and popped on every accepted handshake
module tb_key_event_capture_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];
  key_event_capture_8_if bus ();
  key_event_capture_8 #(.DEBOUNCE_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input int lim);
    for (int c = 0; c < lim && !bus.valid; c++) @(negedge clk);
    chk("wait_valid", {31'd0, bus.valid}, 1);
  endtask
  always @(negedge clk)
    if (rst_n && bus.valid && bus.ready) begin
      if (sb.size() == 0) chk("spurious_valid", {31'd0, bus.valid}, 0);
      else chk("event_o", {24'd0, bus.o}, {24'd0, sb.pop_front()});
    end
  initial begin
    bus.req = '0;
    bus.ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1 bus.req = 8'($urandom);
      bus.ready = 1'($urandom);
      @(negedge clk);
      chk("rst_o", {24'd0, bus.o}, 0);
      chk("rst_valid", {31'd0, bus.valid}, 0);
      chk("rst_overflow", {31'd0, bus.overflow}, 0);
    end
    bus.req = '0;
    bus.ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(15);
    chk("idle_valid", {31'd0, bus.valid}, 0);
    sb.push_back(8'h08);
    bus.req[3] = 1'b1;
    cyc(6);
    @(negedge clk);
    chk("lat_early", {31'd0, bus.valid}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", {31'd0, bus.valid}, 1);
    chk("lat_o", {24'd0, bus.o}, 32'h08);
    @(posedge clk);
    @(negedge clk);
    chk("one_cycle", {31'd0, bus.valid}, 0);
    cyc(2);
    bus.req[3] = 1'b0;
    cyc(15);
    chk("press_sb", sb.size(), 0);
    bus.req[5] = 1'b1;
    cyc(3);
    bus.req[5] = 1'b0;
    cyc(15);
    chk("glitch_overflow", {31'd0, bus.overflow}, 0);
    chk("glitch_sb", sb.size(), 0);
    bus.ready = 1'b0;
    bus.req = 8'h42;
    wait_valid(20);
    chk("prio_o", {24'd0, bus.o}, 32'h40);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_o", {24'd0, bus.o}, 32'h40);
      chk("hold_valid", {31'd0, bus.valid}, 1);
    end
    @(posedge clk);
    #1 sb.push_back(8'h40);
    bus.ready = 1'b1;
    cyc(1);
    bus.ready = 1'b0;
    @(negedge clk);
    chk("next_o", {24'd0, bus.o}, 32'h02);
    chk("next_valid", {31'd0, bus.valid}, 1);
    @(posedge clk);
    #1 sb.push_back(8'h02);
    bus.ready = 1'b1;
    cyc(1);
    bus.ready = 1'b0;
    @(negedge clk);
    chk("drained_valid", {31'd0, bus.valid}, 0);
    bus.req = '0;
    cyc(10);
    chk("prio_sb", sb.size(), 0);
    chk("pre_overflow", {31'd0, bus.overflow}, 0);
    bus.req[7] = 1'b1;
    wait_valid(20);
    chk("ovf_o7", {24'd0, bus.o}, 32'h80);
    @(posedge clk);
    #1 bus.req[2] = 1'b1;
    cyc(8);
    bus.req[2] = 1'b0;
    cyc(8);
    bus.req[2] = 1'b1;
    cyc(8);
    @(negedge clk);
    chk("overflow", {31'd0, bus.overflow}, 1);
    @(posedge clk);
    #1 bus.req = '0;
    sb.push_back(8'h80);
    sb.push_back(8'h04);
    bus.ready = 1'b1;
    cyc(20);
    chk("ovf_sb", sb.size(), 0);
    bus.ready = 1'b0;
    bus.req = 8'h15;
    wait_valid(20);
    chk("mid_o4", {24'd0, bus.o}, 32'h10);
    @(posedge clk);
    #1 bus.req = 8'h10;
    cyc(3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_o", {24'd0, bus.o}, 0);
    chk("async_valid", {31'd0, bus.valid}, 0);
    chk("async_overflow", {31'd0, bus.overflow}, 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back(8'h10);
    bus.ready = 1'b1;
    cyc(6);
    @(negedge clk);
    chk("rel_early", {31'd0, bus.valid}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rel_valid", {31'd0, bus.valid}, 1);
    chk("rel_o", {24'd0, bus.o}, 32'h10);
    cyc(20);
    chk("rel_sb", sb.size(), 0);
    chk("rel_overflow", {31'd0, bus.overflow}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
